// File: rtl/z80_jp_sequencer.sv
// z80_jp_sequencer: operand M-cycles (M2/M3) of JP nn (0xC3) and JP cc,nn.
// Reads nn low/high with 3-T memory reads, evaluates cc against F and issues
// one PC write in M3 T3.
// Optional build macro: Z80_SEQ_WAIT_EN adds wait_n-driven Tw states.

`ifndef CYCLE_NONE
`define CYCLE_NONE 3'd0
`endif
`ifndef CYCLE_RDWR_MEM
`define CYCLE_RDWR_MEM 3'd1
`endif

module z80_jp_sequencer (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [7:0]  opcode,
   input  logic [15:0] pc_in,
   input  logic [7:0]  flags,
   input  logic [7:0]  data_in,
   input  logic        wait_n,
   output logic        busy,
   output logic        mem_rd,
   output logic [15:0] addr,
   output logic [2:0]  mcycle_type,
   output logic [2:0]  tstate,
   output logic        pc_we,
   output logic [15:0] pc_out,
   output logic        done,
   output logic        unsupported
);

   localparam int unsigned AW = 16;
   localparam int unsigned DW = 8;
   localparam int unsigned TW = 3;

   localparam logic [TW-1:0] T_IDLE = 3'd0;
   localparam logic [TW-1:0] T_1    = 3'd1;
   localparam logic [TW-1:0] T_2    = 3'd2;
   localparam logic [TW-1:0] T_3    = 3'd3;
   localparam logic [TW-1:0] T_W    = 3'd4;

   // F register bit positions
   localparam int unsigned F_S  = 7;
   localparam int unsigned F_Z  = 6;
   localparam int unsigned F_PV = 2;
   localparam int unsigned F_C  = 0;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_M2   = 2'd1,
      S_M3   = 2'd2
   } state_e;

   state_e          state_q;
   logic [TW-1:0]   tstate_q;
   logic [AW-1:0]   pc_q;
   logic [DW-1:0]   lo_q;
   logic            uncond_q;
   logic [2:0]      cc_q;
   logic            busy_q;
   logic            mem_rd_q;
   logic [AW-1:0]   addr_q;
   logic [2:0]      mcyc_q;
   logic            unsupported_q;

   logic            is_jp_c;
   logic            is_jp_uncond_c;
   logic            in_m3_t3_c;
   logic            flag_c;
   logic            taken_c;
   logic            wait_req_c;

   // Opcode decode: JP nn and JP cc,nn (11ccc010)
   assign is_jp_uncond_c = (opcode == 8'hC3);
   assign is_jp_c        = is_jp_uncond_c ||
                           ((opcode[7:6] == 2'b11) && (opcode[2:0] == 3'b010));

   // Wait request seen on the edge ending T2 / Tw
`ifdef Z80_SEQ_WAIT_EN
   assign wait_req_c = ~wait_n;
   logic unused_bits;
   assign unused_bits = ^{flags[5:3], flags[1]};
`else
   assign wait_req_c = 1'b0;
   logic unused_bits;
   assign unused_bits = ^{flags[5:3], flags[1], wait_n};
`endif

   // Condition evaluation: cc[2:1] selects the flag, cc[0] selects its polarity
   always_comb begin
      flag_c = 1'b0;
      unique case (cc_q[2:1])
         2'b00:   flag_c = flags[F_Z];
         2'b01:   flag_c = flags[F_C];
         2'b10:   flag_c = flags[F_PV];
         default: flag_c = flags[F_S];
      endcase
      taken_c = uncond_q | (cc_q[0] ? flag_c : ~flag_c);
   end

   // PC write happens combinationally in M3 T3 with the high byte on data_in
   assign in_m3_t3_c = (state_q == S_M3) && (tstate_q == T_3);

   always_comb begin
      pc_out = '0;
      if (in_m3_t3_c) begin
         pc_out = taken_c ? {data_in, lo_q} : AW'(pc_q + 16'd3);
      end
   end

   assign pc_we = in_m3_t3_c;
   assign done  = in_m3_t3_c;

   // Sequencer FSM with registered bus-side outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= S_IDLE;
         tstate_q      <= T_IDLE;
         pc_q          <= '0;
         lo_q          <= '0;
         uncond_q      <= 1'b0;
         cc_q          <= '0;
         busy_q        <= 1'b0;
         mem_rd_q      <= 1'b0;
         addr_q        <= '0;
         mcyc_q        <= `CYCLE_NONE;
         unsupported_q <= 1'b0;
      end else begin
         unsupported_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  if (is_jp_c) begin
                     pc_q     <= pc_in;
                     uncond_q <= is_jp_uncond_c;
                     cc_q     <= opcode[5:3];
                     state_q  <= S_M2;
                     tstate_q <= T_1;
                     busy_q   <= 1'b1;
                     mem_rd_q <= 1'b1;
                     addr_q   <= AW'(pc_in + 16'd1);
                     mcyc_q   <= `CYCLE_RDWR_MEM;
                  end else begin
                     unsupported_q <= 1'b1;
                  end
               end
            end
            S_M2, S_M3: begin
               unique case (tstate_q)
                  T_1: begin
                     tstate_q <= T_2;
                  end
                  T_2, T_W: begin
                     if (wait_req_c) begin
                        tstate_q <= T_W;
                     end else begin
                        tstate_q <= T_3;
                        mem_rd_q <= 1'b0;
                     end
                  end
                  T_3: begin
                     if (state_q == S_M2) begin
                        lo_q     <= data_in;
                        state_q  <= S_M3;
                        tstate_q <= T_1;
                        mem_rd_q <= 1'b1;
                        addr_q   <= AW'(pc_q + 16'd2);
                     end else begin
                        state_q  <= S_IDLE;
                        tstate_q <= T_IDLE;
                        busy_q   <= 1'b0;
                        mem_rd_q <= 1'b0;
                        addr_q   <= '0;
                        mcyc_q   <= `CYCLE_NONE;
                     end
                  end
                  default: begin
                     state_q  <= S_IDLE;
                     tstate_q <= T_IDLE;
                     busy_q   <= 1'b0;
                     mem_rd_q <= 1'b0;
                     addr_q   <= '0;
                     mcyc_q   <= `CYCLE_NONE;
                  end
               endcase
            end
            default: begin
               state_q  <= S_IDLE;
               tstate_q <= T_IDLE;
               busy_q   <= 1'b0;
               mem_rd_q <= 1'b0;
               addr_q   <= '0;
               mcyc_q   <= `CYCLE_NONE;
            end
         endcase
      end
   end

   assign busy        = busy_q;
   assign mem_rd      = mem_rd_q;
   assign addr        = addr_q;
   assign mcycle_type = mcyc_q;
   assign tstate      = tstate_q;
   assign unsupported = unsupported_q;

endmodule

// File: tb/tb_z80_jp_sequencer.sv
// Directed bench for z80_jp_sequencer; follows the Z80_SEQ_WAIT_EN build macro.

`ifndef CYCLE_NONE
`define CYCLE_NONE 3'd0
`endif
`ifndef CYCLE_RDWR_MEM
`define CYCLE_RDWR_MEM 3'd1
`endif

module tb_z80_jp_sequencer;

   logic        clk;
   logic        reset_n;
   logic        start;
   logic [7:0]  opcode;
   logic [15:0] pc_in;
   logic [7:0]  flags;
   logic [7:0]  data_in;
   logic        wait_n;
   logic        busy;
   logic        mem_rd;
   logic [15:0] addr;
   logic [2:0]  mcycle_type;
   logic [2:0]  tstate;
   logic        pc_we;
   logic [15:0] pc_out;
   logic        done;
   logic        unsupported;

   int total = 0;
   int bad   = 0;

   // Two-byte memory model: operand bytes at pc+1 / pc+2, filler elsewhere
   logic [15:0] ma_lo, ma_hi;
   logic [7:0]  mb_lo, mb_hi;
   assign data_in = (addr == ma_lo) ? mb_lo : (addr == ma_hi) ? mb_hi : 8'hEE;

   z80_jp_sequencer dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .start       (start),
      .opcode      (opcode),
      .pc_in       (pc_in),
      .flags       (flags),
      .data_in     (data_in),
      .wait_n      (wait_n),
      .busy        (busy),
      .mem_rd      (mem_rd),
      .addr        (addr),
      .mcycle_type (mcycle_type),
      .tstate      (tstate),
      .pc_we       (pc_we),
      .pc_out      (pc_out),
      .done        (done),
      .unsupported (unsupported)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Full JP run from the current negedge (cycle 0); wait_n low for wcyc cycles from cycle 2
   task automatic run_jp(input string name, input logic [15:0] pc, input logic [7:0] op,
                         input logic [7:0] fl, input logic [7:0] blo, input logic [7:0] bhi,
                         input logic [15:0] exp_pc, input int wcyc);
      int tw;
      logic [15:0] a1, a2, ea;
      logic [2:0]  et;
      logic        eb, em2;
`ifdef Z80_SEQ_WAIT_EN
      tw = wcyc;
`else
      tw = 0;
`endif
      a1 = pc + 16'd1;
      a2 = pc + 16'd2;
      ma_lo = a1; ma_hi = a2; mb_lo = blo; mb_hi = bhi;
      start = 1'b1; opcode = op; pc_in = pc; flags = fl; wait_n = 1'b1;
      for (int c = 1; c <= 7 + tw; c++) begin
         @(negedge clk);
         // a bogus start while busy must be ignored
         start  = (c == 3);
         opcode = (c == 3) ? 8'h00 : op;
         wait_n = !(c >= 2 && c < 2 + wcyc);
         if (c == 1)               et = 3'd1;
         else if (c == 2)          et = 3'd2;
         else if (c <= 2 + tw)     et = 3'd4;
         else if (c == 3 + tw)     et = 3'd3;
         else if (c == 4 + tw)     et = 3'd1;
         else if (c == 5 + tw)     et = 3'd2;
         else if (c == 6 + tw)     et = 3'd3;
         else                      et = 3'd0;
         eb  = (c <= 6 + tw);
         em2 = (c <= 3 + tw);
         ea  = !eb ? 16'h0000 : (em2 ? a1 : a2);
         chk($sformatf("%s c%0d tstate", name, c), 32'(tstate), 32'(et));
         chk($sformatf("%s c%0d busy", name, c), 32'(busy), 32'(eb));
         chk($sformatf("%s c%0d mem_rd", name, c), 32'(mem_rd),
             32'(et == 3'd1 || et == 3'd2 || et == 3'd4));
         chk($sformatf("%s c%0d addr", name, c), 32'(addr), 32'(ea));
         chk($sformatf("%s c%0d mcyc", name, c), 32'(mcycle_type),
             32'(eb ? `CYCLE_RDWR_MEM : `CYCLE_NONE));
         chk($sformatf("%s c%0d pc_we", name, c), 32'(pc_we), 32'(c == 6 + tw));
         chk($sformatf("%s c%0d done", name, c), 32'(done), 32'(c == 6 + tw));
         chk($sformatf("%s c%0d pc_out", name, c), 32'(pc_out),
             32'((c == 6 + tw) ? exp_pc : 16'h0000));
         chk($sformatf("%s c%0d unsup", name, c), 32'(unsupported), 32'(0));
      end
      start = 1'b0;
      wait_n = 1'b1;
   endtask

   initial begin
      reset_n = 1'b0; start = 1'b0; opcode = 8'h00; pc_in = 16'h0000; flags = 8'h00;
      wait_n = 1'b1; ma_lo = 16'h0000; ma_hi = 16'h0000; mb_lo = 8'h00; mb_hi = 8'h00;

      repeat (2) @(negedge clk);
      chk("rst busy", 32'(busy), 32'(0));
      chk("rst mem_rd", 32'(mem_rd), 32'(0));
      chk("rst addr", 32'(addr), 32'(0));
      chk("rst tstate", 32'(tstate), 32'(0));
      chk("rst mcyc", 32'(mcycle_type), 32'(`CYCLE_NONE));
      chk("rst pc_we", 32'(pc_we), 32'(0));
      chk("rst pc_out", 32'(pc_out), 32'(0));
      reset_n = 1'b1;

      @(negedge clk);
      run_jp("jp_nn", 16'h0100, 8'hC3, 8'h00, 8'h34, 8'h12, 16'h1234, 0);
      run_jp("jpz_t", 16'h2000, 8'hCA, 8'h40, 8'h00, 8'h80, 16'h8000, 0);
      run_jp("jpz_nt", 16'h2000, 8'hCA, 8'h00, 8'h00, 8'h80, 16'h2003, 0);
      run_jp("jpm_wrap", 16'hFFFE, 8'hFA, 8'h00, 8'h11, 8'h22, 16'h0001, 0);
      run_jp("jpnc_nt", 16'h3000, 8'hD2, 8'h01, 8'h78, 8'h56, 16'h3003, 0);
      run_jp("jpc_t", 16'h3000, 8'hDA, 8'h01, 8'h78, 8'h56, 16'h5678, 0);
      run_jp("jppe_t", 16'h4444, 8'hEA, 8'h04, 8'hCD, 8'hAB, 16'hABCD, 0);
      run_jp("jppo_nt", 16'h4444, 8'hE2, 8'h04, 8'hCD, 8'hAB, 16'h4447, 0);
      run_jp("jpp_t", 16'h5000, 8'hF2, 8'h40, 8'h02, 8'h01, 16'h0102, 0);
      run_jp("jpnz_nt", 16'h5000, 8'hC2, 8'h40, 8'h02, 8'h01, 16'h5003, 0);

      // Unsupported opcode: one-cycle pulse, never busy
      start = 1'b1; opcode = 8'h00; pc_in = 16'h6000;
      @(negedge clk);
      start = 1'b0;
      chk("unsup pulse", 32'(unsupported), 32'(1));
      chk("unsup busy", 32'(busy), 32'(0));
      chk("unsup mem_rd", 32'(mem_rd), 32'(0));
      @(negedge clk);
      chk("unsup end", 32'(unsupported), 32'(0));
      chk("unsup busy2", 32'(busy), 32'(0));

      // Reset mid-instruction (M3 T2)
      ma_lo = 16'h7001; ma_hi = 16'h7002; mb_lo = 8'h99; mb_hi = 8'h88;
      start = 1'b1; opcode = 8'hC3; pc_in = 16'h7000;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         start = 1'b0;
      end
      chk("pre-rst tstate", 32'(tstate), 32'(2));
      reset_n = 1'b0;
      #1;
      chk("mid-rst busy", 32'(busy), 32'(0));
      chk("mid-rst mem_rd", 32'(mem_rd), 32'(0));
      chk("mid-rst addr", 32'(addr), 32'(0));
      chk("mid-rst tstate", 32'(tstate), 32'(0));
      chk("mid-rst pc_we", 32'(pc_we), 32'(0));
      @(negedge clk);
      chk("mid-rst pc_we2", 32'(pc_we), 32'(0));
      chk("mid-rst done", 32'(done), 32'(0));
      reset_n = 1'b1;
      run_jp("after_rst", 16'h0100, 8'hC3, 8'h00, 8'h34, 8'h12, 16'h1234, 0);

      // wait_n low for two samples in M2 (Tw only in the wait-enabled build)
      run_jp("wait2", 16'h0100, 8'hC3, 8'h00, 8'h34, 8'h12, 16'h1234, 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
